// File: rtl/piece_mover.sv
// Falling-tetromino controller: spawns a piece, applies gravity and player moves,
// checks collisions against the 12 board rows and requests lock-in when the piece lands.
module piece_mover #(
  parameter int unsigned DROP_TICKS = 25_000_000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       gen_flag,
  input  logic       Left,
  input  logic       Right,
  input  logic       Rot,
  input  logic       Down,
  input  logic [9:0] row0,
  input  logic [9:0] row1,
  input  logic [9:0] row2,
  input  logic [9:0] row3,
  input  logic [9:0] row4,
  input  logic [9:0] row5,
  input  logic [9:0] row6,
  input  logic [9:0] row7,
  input  logic [9:0] row8,
  input  logic [9:0] row9,
  input  logic [9:0] row10,
  input  logic [9:0] row11,
  output logic [3:0] x1,
  output logic [3:0] y1,
  output logic [3:0] x2,
  output logic [3:0] y2,
  output logic [3:0] x3,
  output logic [3:0] y3,
  output logic [3:0] x4,
  output logic [3:0] y4,
  output logic [2:0] piece_type,
  output logic       bottom_flag,
  output logic       top_flag,
  output logic [2:0] state
);

  localparam int unsigned CntW = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;
  localparam logic [2:0]  TypeO = 3'd2;

  typedef enum logic [2:0] {
    StSpawn = 3'b000,
    StIdle  = 3'b001,
    StFall  = 3'b010,
    StLand  = 3'b011,
    StLost  = 3'b100
  } state_e;

  state_e            r_state, w_state_d;
  logic [3:0]        r_x [4];
  logic [3:0]        r_y [4];
  logic [3:0]        w_x_d [4];
  logic [3:0]        w_y_d [4];
  logic [2:0]        r_type, w_type_d;
  logic              r_top, w_top_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [2:0]        r_lfsr;

  logic [11:0][9:0]  w_board;
  logic signed [4:0] w_dx [4];
  logic signed [4:0] w_dy [4];
  logic signed [4:0] w_cur_x [4];
  logic signed [4:0] w_cur_y [4];
  logic signed [4:0] w_cx [4];
  logic signed [4:0] w_cy [4];
  logic signed [4:0] w_sx [4];
  logic signed [4:0] w_sy [4];
  logic              w_tick, w_act, w_drop, w_cand_ok, w_spawn_ok;

  assign w_board = {row11, row10, row9, row8, row7, row6, row5, row4, row3, row2, row1, row0};
  assign w_tick  = (r_cnt == CntW'(DROP_TICKS - 1));

  // Cell is usable if inside the 10x12 field and its board bit is clear; row bit (9-x) is x.
  function automatic logic cell_free(input logic signed [4:0] cx, input logic signed [4:0] cy,
                                     input logic [11:0][9:0] board);
    logic free;
    free = 1'b0;
    if (cx >= 5'sd0 && cx <= 5'sd9 && cy >= 5'sd0 && cy <= 5'sd11) begin
      free = ~board[cy[3:0]][4'd9 - cx[3:0]];
    end
    return free;
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_dx[i] = 5'sd0;
      w_dy[i] = 5'sd0;
    end
    unique case (r_type)
      3'd1: begin  // I
        w_dx[0] = -5'sd1; w_dx[2] = 5'sd1; w_dx[3] = 5'sd2;
      end
      3'd2: begin  // O
        w_dy[0] = -5'sd1; w_dx[2] = 5'sd1; w_dy[2] = -5'sd1; w_dx[3] = 5'sd1;
      end
      3'd3: begin  // T
        w_dx[0] = -5'sd1; w_dx[2] = 5'sd1; w_dy[3] = -5'sd1;
      end
      3'd4: begin  // S
        w_dx[0] = -5'sd1; w_dy[2] = -5'sd1; w_dx[3] = 5'sd1; w_dy[3] = -5'sd1;
      end
      3'd5: begin  // Z
        w_dx[0] = -5'sd1; w_dy[0] = -5'sd1; w_dy[2] = -5'sd1; w_dx[3] = 5'sd1;
      end
      3'd6: begin  // J
        w_dx[0] = -5'sd1; w_dy[0] = -5'sd1; w_dx[2] = -5'sd1; w_dx[3] = 5'sd1;
      end
      3'd7: begin  // L
        w_dx[0] = 5'sd1; w_dy[0] = -5'sd1; w_dx[2] = -5'sd1; w_dx[3] = 5'sd1;
      end
      default: ;
    endcase
  end

  // Candidate position for this cycle's single highest-priority action.
  always_comb begin
    w_act      = 1'b0;
    w_drop     = 1'b0;
    w_cand_ok  = 1'b1;
    w_spawn_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_cur_x[i] = $signed({1'b0, r_x[i]});
      w_cur_y[i] = $signed({1'b0, r_y[i]});
      w_cx[i]    = w_cur_x[i];
      w_cy[i]    = w_cur_y[i];
      w_sx[i]    = 5'sd4 + w_dx[i];
      w_sy[i]    = 5'sd1 + w_dy[i];
    end
    if (Rot) begin
      if (r_type != TypeO) begin
        w_act = 1'b1;
        for (int i = 0; i < 4; i++) begin
          w_cx[i] = w_cur_x[1] - (w_cur_y[i] - w_cur_y[1]);
          w_cy[i] = w_cur_y[1] + (w_cur_x[i] - w_cur_x[1]);
        end
      end
    end else if (Left) begin
      w_act = 1'b1;
      for (int i = 0; i < 4; i++) w_cx[i] = w_cur_x[i] - 5'sd1;
    end else if (Right) begin
      w_act = 1'b1;
      for (int i = 0; i < 4; i++) w_cx[i] = w_cur_x[i] + 5'sd1;
    end else if (Down || w_tick) begin
      w_act  = 1'b1;
      w_drop = 1'b1;
      for (int i = 0; i < 4; i++) w_cy[i] = w_cur_y[i] + 5'sd1;
    end
    for (int i = 0; i < 4; i++) begin
      w_cand_ok  = w_cand_ok & cell_free(w_cx[i], w_cy[i], w_board);
      w_spawn_ok = w_spawn_ok & cell_free(w_sx[i], w_sy[i], w_board);
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_type_d  = r_type;
    w_top_d   = r_top;
    w_cnt_d   = r_cnt;
    for (int i = 0; i < 4; i++) begin
      w_x_d[i] = r_x[i];
      w_y_d[i] = r_y[i];
    end
    unique case (r_state)
      StIdle: begin
        if (gen_flag) begin
          w_type_d  = r_lfsr;
          w_state_d = StSpawn;
        end
      end
      StSpawn: begin
        for (int i = 0; i < 4; i++) begin
          w_x_d[i] = w_sx[i][3:0];
          w_y_d[i] = w_sy[i][3:0];
        end
        if (w_spawn_ok) begin
          w_cnt_d   = '0;
          w_state_d = StFall;
        end else begin
          w_top_d   = 1'b1;
          w_state_d = StLost;
        end
      end
      StFall: begin
        w_cnt_d = w_tick ? '0 : r_cnt + 1'b1;
        if (w_act) begin
          if (w_cand_ok) begin
            for (int i = 0; i < 4; i++) begin
              w_x_d[i] = w_cx[i][3:0];
              w_y_d[i] = w_cy[i][3:0];
            end
            if (w_drop) w_cnt_d = '0;
          end else if (w_drop) begin
            w_state_d = StLand;
          end
        end
      end
      StLand: w_state_d = StIdle;
      StLost: begin
        if (gen_flag) begin
          w_top_d   = 1'b0;
          w_type_d  = r_lfsr;
          w_state_d = StSpawn;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= StIdle;
      r_type  <= 3'd0;
      r_top   <= 1'b0;
      r_cnt   <= '0;
      r_lfsr  <= 3'b001;
      for (int i = 0; i < 4; i++) begin
        r_x[i] <= 4'd0;
        r_y[i] <= 4'd0;
      end
    end else begin
      r_state <= w_state_d;
      r_type  <= w_type_d;
      r_top   <= w_top_d;
      r_cnt   <= w_cnt_d;
      r_lfsr  <= {r_lfsr[1:0], r_lfsr[2] ^ r_lfsr[1]};
      for (int i = 0; i < 4; i++) begin
        r_x[i] <= w_x_d[i];
        r_y[i] <= w_y_d[i];
      end
    end
  end

  assign x1          = r_x[0];
  assign y1          = r_y[0];
  assign x2          = r_x[1];
  assign y2          = r_y[1];
  assign x3          = r_x[2];
  assign y3          = r_y[2];
  assign x4          = r_x[3];
  assign y4          = r_y[3];
  assign piece_type  = r_type;
  assign top_flag    = r_top;
  assign bottom_flag = (r_state == StLand);
  assign state       = r_state;

endmodule

// File: tb/tb_piece_mover.sv
// Directed bench for piece_mover with DROP_TICKS=4; cell coords are checked packed as
// hex pairs {x1,y1,x2,y2,x3,y3,x4,y4}.
module tb_piece_mover;

  logic       Clk = 1'b0;
  logic       Reset, gen_flag, Left, Right, Rot, Down;
  logic [9:0] rows [12];
  logic [3:0] x1, y1, x2, y2, x3, y3, x4, y4;
  logic [2:0] piece_type, state;
  logic       bottom_flag, top_flag;

  int          total = 0;
  int          bad   = 0;
  int unsigned t_lfsr;
  logic [2:0]  lfsr_seq [7];

  piece_mover #(.DROP_TICKS(4)) dut (
    .Clk(Clk), .Reset(Reset), .gen_flag(gen_flag),
    .Left(Left), .Right(Right), .Rot(Rot), .Down(Down),
    .row0(rows[0]), .row1(rows[1]), .row2(rows[2]), .row3(rows[3]),
    .row4(rows[4]), .row5(rows[5]), .row6(rows[6]), .row7(rows[7]),
    .row8(rows[8]), .row9(rows[9]), .row10(rows[10]), .row11(rows[11]),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3), .x4(x4), .y4(y4),
    .piece_type(piece_type), .bottom_flag(bottom_flag), .top_flag(top_flag),
    .state(state)
  );

  always #5 Clk = ~Clk;

  // Edges since reset release; the x^3+x^2+1 sequence from 001 is 1,2,5,3,7,6,4.
  always @(posedge Clk) begin
    if (Reset) t_lfsr <= 0;
    else       t_lfsr <= t_lfsr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic cells(input string tag, input logic [31:0] exp);
    chk(tag, {x1, y1, x2, y2, x3, y3, x4, y4}, exp);
  endtask

  // Pulse gen_flag in the cycle where the LFSR holds the wanted type; ends in SPAWN.
  task automatic gen_piece(input logic [2:0] want);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      if (lfsr_seq[t_lfsr % 7] == want) begin
        gen_flag = 1'b1;
        cyc(1);
        gen_flag = 1'b0;
        got = 1'b1;
      end else begin
        cyc(1);
      end
    end
    chk("lfsr_reach", {31'd0, got}, 32'd1);
  endtask

  task automatic pulse_left(input int n);
    for (int k = 0; k < n; k++) begin
      Left = 1'b1; cyc(1); Left = 1'b0;
    end
  endtask

  task automatic pulse_right(input int n);
    for (int k = 0; k < n; k++) begin
      Right = 1'b1; cyc(1); Right = 1'b0;
    end
  endtask

  task automatic pulse_down(input int n);
    for (int k = 0; k < n; k++) begin
      Down = 1'b1; cyc(1); Down = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    lfsr_seq = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd7, 3'd6, 3'd4};
    Reset = 1'b1; gen_flag = 1'b0; Left = 1'b0; Right = 1'b0; Rot = 1'b0; Down = 1'b0;
    for (int r = 0; r < 12; r++) rows[r] = 10'd0;
    cyc(2);
    chk("rst_state", {29'd0, state}, 32'h1);
    cells("rst_cells", 32'h0);
    chk("rst_type", {29'd0, piece_type}, 32'h0);
    chk("rst_flags", {30'd0, bottom_flag, top_flag}, 32'h0);
    Reset = 1'b0;

    // I piece falls the whole way on an empty board
    gen_piece(3'd1);
    chk("spawn_state", {29'd0, state}, 32'h0);
    cyc(1);
    cells("i_spawn", 32'h31415161);
    chk("i_fall_state", {29'd0, state}, 32'h2);
    chk("i_type", {29'd0, piece_type}, 32'h1);
    cyc(40);
    cells("i_y11", 32'h3B4B5B6B);
    cyc(3);
    chk("i_no_land_yet", {31'd0, bottom_flag}, 32'h0);
    cyc(1);
    chk("i_bottom", {31'd0, bottom_flag}, 32'h1);
    chk("i_land_state", {29'd0, state}, 32'h3);
    cells("i_land_cells", 32'h3B4B5B6B);
    cyc(1);
    chk("i_bottom_once", {31'd0, bottom_flag}, 32'h0);
    chk("i_idle", {29'd0, state}, 32'h1);
    cells("i_hold", 32'h3B4B5B6B);

    // Wall limits, rotation, blocked rotation, soft drop
    gen_piece(3'd1);
    cyc(1);
    pulse_left(3);
    cells("left3", 32'h01112131);
    pulse_left(1);
    cells("left_wall", 32'h01112131);
    pulse_right(7);
    cells("right_wall", 32'h61718191);
    Rot = 1'b1; cyc(1); Rot = 1'b0;
    cells("i_rot", 32'h70717273);
    pulse_left(7);
    cells("i_vert_x0", 32'h00010203);
    Rot = 1'b1; cyc(1); Rot = 1'b0;
    cells("rot_blocked", 32'h00010203);
    pulse_down(1);
    cells("soft_drop", 32'h01020304);
    pulse_down(7);
    cells("floor_reach", 32'h08090A0B);

    // Reset wins over a Down that would otherwise land the piece
    Reset = 1'b1; Down = 1'b1;
    cyc(1);
    chk("rst_mid_state", {29'd0, state}, 32'h1);
    cells("rst_mid_cells", 32'h0);
    chk("rst_mid_type", {29'd0, piece_type}, 32'h0);
    chk("rst_mid_bottom", {31'd0, bottom_flag}, 32'h0);
    cyc(1);
    Reset = 1'b0; Down = 1'b0;
    cyc(1);
    chk("rst_after_bottom", {31'd0, bottom_flag}, 32'h0);
    chk("rst_after_state", {29'd0, state}, 32'h1);

    // O piece lands on a full bottom row
    rows[11] = 10'h3FF;
    gen_piece(3'd2);
    cyc(1);
    cells("o_spawn", 32'h40415051);
    chk("o_type", {29'd0, piece_type}, 32'h2);
    cyc(36);
    cells("o_rest", 32'h494A595A);
    cyc(3);
    chk("o_no_land_yet", {31'd0, bottom_flag}, 32'h0);
    cyc(1);
    chk("o_bottom", {31'd0, bottom_flag}, 32'h1);
    cells("o_land_cells", 32'h494A595A);
    cyc(1);
    chk("o_bottom_once", {31'd0, bottom_flag}, 32'h0);
    chk("o_idle", {29'd0, state}, 32'h1);

    // Blocked spawn, then recovery
    rows[11] = 10'd0;
    rows[1]  = 10'h3FF;
    gen_piece(3'd5);
    chk("lost_spawn_state", {29'd0, state}, 32'h0);
    chk("lost_top_pre", {31'd0, top_flag}, 32'h0);
    cyc(1);
    chk("lost_state", {29'd0, state}, 32'h4);
    chk("lost_top", {31'd0, top_flag}, 32'h1);
    chk("lost_type", {29'd0, piece_type}, 32'h5);
    pulse_left(1);
    cyc(2);
    chk("lost_hold_state", {29'd0, state}, 32'h4);
    chk("lost_hold_top", {31'd0, top_flag}, 32'h1);
    rows[1] = 10'd0;
    gen_piece(3'd3);
    chk("regen_top", {31'd0, top_flag}, 32'h0);
    chk("regen_spawn", {29'd0, state}, 32'h0);
    cyc(1);
    chk("t_fall", {29'd0, state}, 32'h2);
    chk("t_type", {29'd0, piece_type}, 32'h3);
    cells("t_spawn", 32'h31415140);

    // Rot beats Left in the same cycle; the stem swings to the right of the pivot
    Rot = 1'b1; Left = 1'b1;
    cyc(1);
    Rot = 1'b0; Left = 1'b0;
    cells("t_rot_prio", 32'h40414251);
    gen_flag = 1'b1;
    cyc(1);
    gen_flag = 1'b0;
    chk("gen_ignored_state", {29'd0, state}, 32'h2);
    chk("gen_ignored_type", {29'd0, piece_type}, 32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
